// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline stage register with handshake, stall, flush and bubble insertion
//
// Purpose:
//   One register slice placed between two pipeline stages. It carries the
//   control and data bundles opaquely and also carries the register-file write
//   port. A load-use bubble inserts a NOP without consuming upstream. A flush
//   discards the stage contents and the input. wb_kill suppresses the write
//   enable of the instruction being captured.
//
// Build option:
//   PIPE_SKID_EN - adds a one-entry skid buffer, so in_ready depends only on
//                  registered state (plus bubble/flush) and not on out_ready.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready        upstream handshake
//   in_ctrl, in_data           control / data bundles
//   in_wen, in_waddr           register-file write enable / destination
//   wb_kill                    drop in_wen of the captured instruction
//   flush                      discard stage contents and this cycle's input
//   bubble                     insert one NOP and hold upstream
//   out_valid / out_ready      downstream handshake
//   out_ctrl, out_data         registered bundles
//   out_wen, out_waddr         registered write port
//   out_bubble                 current out_* is an inserted bubble

module pipe_stage_reg #(
  parameter int CTRL_W  = 8,
  parameter int DATA_W  = 192,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_wen,
  input  logic [RADDR_W-1:0] in_waddr,
  input  logic               wb_kill,
  input  logic               flush,
  input  logic               bubble,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_wen,
  output logic [RADDR_W-1:0] out_waddr,
  output logic               out_bubble
);

  // The output slot can take a new word when it is empty or is being emptied now.
  logic slot_free;
  logic accept;
  logic cap_wen;

  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  // The write enable is qualified once, at capture, so a killed instruction
  // never shows out_wen, even if it waits in the skid entry.
  assign cap_wen   = in_wen && !wb_kill;

`ifdef PIPE_SKID_EN

  logic               skid_full;
  logic [CTRL_W-1:0]  skid_ctrl;
  logic [DATA_W-1:0]  skid_data;
  logic               skid_wen;
  logic [RADDR_W-1:0] skid_waddr;

  // Ready comes from registered state only. The skid entry absorbs the word
  // that arrives while the output is stalling.
  assign in_ready = !skid_full && !bubble && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      out_wen    <= 1'b0;
      out_waddr  <= '0;
      out_bubble <= 1'b0;
      skid_full  <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      skid_wen   <= 1'b0;
      skid_waddr <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      out_wen    <= 1'b0;
      out_waddr  <= '0;
      out_bubble <= 1'b0;
      skid_full  <= 1'b0;
    end else if (slot_free) begin
      if (skid_full) begin
        // The skid word is older than anything upstream, so it goes first.
        // A pending bubble waits behind it.
        out_valid  <= 1'b1;
        out_ctrl   <= skid_ctrl;
        out_data   <= skid_data;
        out_wen    <= skid_wen;
        out_waddr  <= skid_waddr;
        out_bubble <= 1'b0;
        skid_full  <= 1'b0;
      end else if (bubble) begin
        out_valid  <= 1'b1;
        out_ctrl   <= '0;
        out_data   <= '0;
        out_wen    <= 1'b0;
        out_waddr  <= '0;
        out_bubble <= 1'b1;
      end else if (accept) begin
        out_valid  <= 1'b1;
        out_ctrl   <= in_ctrl;
        out_data   <= in_data;
        out_wen    <= cap_wen;
        out_waddr  <= in_waddr;
        out_bubble <= 1'b0;
      end else if (out_valid) begin
        // Drain: the data may stay stale, but no write is signalled while invalid.
        out_valid  <= 1'b0;
        out_wen    <= 1'b0;
        out_bubble <= 1'b0;
      end
    end else if (accept) begin
      // The output is stalled and the word is parked in the skid entry.
      skid_full  <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
      skid_wen   <= cap_wen;
      skid_waddr <= in_waddr;
    end
  end

`else

  assign in_ready = slot_free && !bubble && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      out_wen    <= 1'b0;
      out_waddr  <= '0;
      out_bubble <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      out_wen    <= 1'b0;
      out_waddr  <= '0;
      out_bubble <= 1'b0;
    end else if (bubble && slot_free) begin
      // A NOP occupies the slot and upstream is not consumed.
      out_valid  <= 1'b1;
      out_ctrl   <= '0;
      out_data   <= '0;
      out_wen    <= 1'b0;
      out_waddr  <= '0;
      out_bubble <= 1'b1;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_ctrl   <= in_ctrl;
      out_data   <= in_data;
      out_wen    <= cap_wen;
      out_waddr  <= in_waddr;
      out_bubble <= 1'b0;
    end else if (out_valid && out_ready) begin
      // Drain: the data may stay stale, but no write is signalled while invalid.
      out_valid  <= 1'b0;
      out_wen    <= 1'b0;
      out_bubble <= 1'b0;
    end
  end

`endif

endmodule
